store_buffer: RTL
=================

# store_buffer

Store buffer between the MEM stage and data memory. Retired stores are queued in a small in-order FIFO and drained to memory through a valid/ready write port. Loads that hit a queued store receive the youngest matching data directly from the buffer. This is the store→load direction of the memory-stage forwarding path, complementing the existing load→store forwarding.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `AW`, default 32: byte-address width.
- `DW`, default 32: data width. Fixed at 32 (one word, 4 byte strobes).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous reset, active-low.
- `st_valid`, input, 1: MEM stage presents a store this cycle.
- `st_addr`, input, AW: store byte address. Only `[AW-1:2]` is stored.
- `st_data`, input, DW: store data, byte-lane aligned.
- `st_strb`, input, 4: byte enables.
- `st_ready`, output, 1: buffer can accept a store (not full).
- `ld_valid`, input, 1: MEM stage presents a load this cycle.
- `ld_addr`, input, AW: load address. Word compare on `[AW-1:2]`.
- `ld_hit`, output, 1: youngest matching entry covers all 4 bytes; `ld_data` is valid.
- `ld_data`, output, DW: forwarded data; 0 when `ld_hit`=0.
- `ld_conflict`, output, 1: youngest matching entry is partial. The pipeline must stall the load.
- `mem_wvalid`, output, 1: head entry is presented to memory.
- `mem_waddr`, output, AW: head address, with `[1:0]`=0.
- `mem_wdata`, output, DW: head data.
- `mem_wstrb`, output, 4: head strobes.
- `mem_wready`, input, 1: memory accepts the head this cycle.
- `empty`, output, 1: no entries (fence/drain indication).
- `count`, output, $clog2(DEPTH)+1: occupancy.

## Operation

- **Storage.** Circular FIFO with `wr_ptr`, `rd_ptr` and `count` registers. Each entry holds `{addr[AW-1:2], data, strb}`.
- **Push.** Occurs when `st_valid & st_ready`; writes entry `wr_ptr` and increments it. `st_ready = (count != DEPTH)`. A push is refused when full, even if a pop happens in the same cycle.
- **Pop.** Occurs when `mem_wvalid & mem_wready`; increments `rd_ptr`. `mem_wvalid = (count != 0)`, and `mem_w*` are driven from entry `rd_ptr`.
- **Simultaneous push and pop.** Allowed when not full; `count` is unchanged.
- **Pointer wrap.** Pointers are modulo DEPTH.
- **Load lookup (combinational).**
  - Compare `ld_addr[AW-1:2]` against all occupied entries. The entry being popped this cycle still counts.
  - Select the youngest matching entry, i.e. the one closest to `wr_ptr-1`.
  - If no match: `ld_hit`=0 and `ld_conflict`=0; the load goes to memory.
  - If the youngest match has `strb==4'hF`: `ld_hit`=1 and `ld_data` = that entry's data.
  - Otherwise: `ld_conflict`=1 and `ld_hit`=0. No byte merging across entries.
  - When `ld_valid`=0, `ld_hit` and `ld_conflict` are 0.
- **Same-cycle store and load.** A store being pushed in the same cycle is not visible to that cycle's load. Program order guarantees the load follows the store by at least one cycle.

## Timing

- **Reset** (`rst_n`=0 at a clock edge): pointers and `count` are cleared.
  - Outputs after reset: `st_ready`=1, `mem_wvalid`=0, `empty`=1, `count`=0, `ld_hit`=0, `ld_conflict`=0, `ld_data`=0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all queued stores; there is no drain.
- **Store latency.** A store pushed at edge N appears at `mem_wvalid` in cycle N+1 if the buffer was empty, and is forwardable from cycle N+1.
- **Write channel rules.**
  - Head data is stable while `mem_wvalid`=1 and `mem_wready`=0.
  - `mem_wvalid` never drops without a pop.
  - `mem_wready` may be asserted with `mem_wvalid`=0; it has no effect.
- **Load path.** Lookup is zero-latency: outputs depend combinationally on `ld_*` and current state. There is no combinational path from `mem_wready` to `ld_*`.
- **Status outputs.** `empty` and `count` are registered-state derived and reflect the state after the last edge.

## Structure

- **Package `sb_pkg`:**
  - `sb_entry_t` struct `{addr, data, strb}`.
  - `STRB_FULL = 4'hF`.
  - Default `DEPTH`/`AW` localparams.
- **Sub-module `sb_match`:** purely combinational youngest-match priority finder.
  - Inputs: per-entry match vector, `rd_ptr`, `count`.
  - Outputs: `hit_any` and `hit_idx`.
  - Implementation: rotate by `rd_ptr`, then pick the highest occupied match.
- **Top level:** holds the FIFO registers, pointer logic and output muxing.

## Test plan

- **Reset then single store.** Store 0x100/0xDEADBEEF/F with `mem_wready`=0.
  - Next cycle `mem_wvalid`=1, `mem_waddr`=0x100, `count`=1.
  - Load 0x102 gives `ld_hit`=1, `ld_data`=0xDEADBEEF.
- **Fill and backpressure.** 4 stores with `mem_wready`=0 give `st_ready`=0 and `count`=4.
  - A 5th `st_valid` is ignored.
  - Raising `mem_wready` drains in order, one per cycle, then `empty`=1.
- **Youngest wins.** Store 0x40=0x11111111, then 0x40=0x22222222, both full strobes. Load 0x40 gives `ld_data`=0x22222222.
- **Partial conflict.** Store 0x80=0xAAAAAAAA/F, then 0x80 with strb=4'h1.
  - Load 0x80 gives `ld_conflict`=1, `ld_hit`=0.
  - After both pop, the load gives no hit and no conflict.
- **Wrap and simultaneous push/pop.** Hold `count`=2 while pushing and popping every cycle for 10 cycles.
  - Memory receives all stores in order and `count` stays 2.
- **Reset mid-drain.** With 3 queued and `mem_wready`=1, assert `rst_n`=0 for one cycle.
  - Next cycle `mem_wvalid`=0, `count`=0, and no further writes are issued.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer between the MEM stage and data memory.
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  localparam logic [3:0] STRB_FULL = 4'hF;

  typedef struct packed {
    logic [SB_AW-3:0] addr;
    logic [SB_DW-1:0] data;
    logic [3:0]       strb;
  } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Youngest-match finder: walks occupied slots oldest to youngest, the last hit wins.
module sb_match #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [PW-1:0]    rd_ptr_i,
  input  logic [CW-1:0]    count_i,
  output logic             hit_any_o,
  output logic [PW-1:0]    hit_idx_o
);
  logic [PW-1:0] idx;

  // Offset i from rd_ptr is age rank; pointer add wraps naturally for power-of-two DEPTH.
  always_comb begin
    hit_any_o = 1'b0;
    hit_idx_o = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_i + PW'(i);
      if ((CW'(i) < count_i) && match_i[idx]) begin
        hit_any_o = 1'b1;
        hit_idx_o = idx;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO drained over a valid/ready write port, with
// youngest-entry store-to-load forwarding for full-word hits.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [3:0]    st_strb,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          ld_conflict,
  output logic          mem_wvalid,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_wready,
  output logic          empty,
  output logic [CW-1:0] count
);
  sb_entry_t     ent_q [DEPTH];
  sb_entry_t     head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign st_ready   = (cnt_q != CW'(DEPTH));
  assign mem_wvalid = (cnt_q != '0);
  assign push       = st_valid & st_ready;
  assign pop        = mem_wvalid & mem_wready;
  assign empty      = (cnt_q == '0);
  assign count      = cnt_q;

  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_q].addr <= (SB_AW-2)'(st_addr[AW-1:2]);
      ent_q[wr_q].data <= SB_DW'(st_data);
      ent_q[wr_q].strb <= st_strb;
    end
  end

  assign head      = ent_q[rd_q];
  assign mem_waddr = {(AW-2)'(head.addr), 2'b00};
  assign mem_wdata = DW'(head.data);
  assign mem_wstrb = head.strb;

  // Lookup uses only registered state, so mem_wready never reaches ld_*.
  logic [DEPTH-1:0] match;
  logic             hit_any;
  logic [PW-1:0]    hit_idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = (ent_q[g].addr == (SB_AW-2)'(ld_addr[AW-1:2]));
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .match_i   (match),
    .rd_ptr_i  (rd_q),
    .count_i   (cnt_q),
    .hit_any_o (hit_any),
    .hit_idx_o (hit_idx)
  );

  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    if (ld_valid && hit_any) begin
      if (ent_q[hit_idx].strb == STRB_FULL) begin
        ld_hit  = 1'b1;
        ld_data = DW'(ent_q[hit_idx].data);
      end else begin
        ld_conflict = 1'b1;
      end
    end
  end
endmodule
